dmem_arbiter: RTL

//  Shares the single data-memory port (DataMem) between the CPU load/store path and
//  a second bus master (UART loader / DMA engine). The CPU has priority. A starvation

---
 rtl/dmem_arbiter.sv | 107 ++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the DataMem port between the CPU load/store path and a DMA master
//   CPU has priority; a blocked DMA request is force-granted after MAX_WAIT cycles and
//   then owns the bus for at most BURST_MAX beats while the CPU is stalled.
//   i_clk, i_rst_n           clock, asynchronous active-low reset
//   i_cpu_rd/wr/addr/wdata   CPU access; o_cpu_rdata load data; o_cpu_stall freeze CPU
//   i_dma_req/we/addr/wdata  DMA beat request held until o_dma_gnt
//   o_dma_gnt                beat accepted at the closing edge of this cycle
//   o_dma_ack/o_dma_rdata    pulse and read data the cycle after an accepted beat
//   o_mem_rd/wr/addr/wdata   to DataMem; i_mem_rdata combinational read data
module dmem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int MAX_WAIT = 8,
  parameter int BURST_MAX = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_cpu_rd,
  input  logic          i_cpu_wr,
  input  logic [AW-1:0] i_cpu_addr,
  input  logic [DW-1:0] i_cpu_wdata,
  output logic [DW-1:0] o_cpu_rdata,
  output logic          o_cpu_stall,
  input  logic          i_dma_req,
  input  logic          i_dma_we,
  input  logic [AW-1:0] i_dma_addr,
  input  logic [DW-1:0] i_dma_wdata,
  output logic          o_dma_gnt,
  output logic          o_dma_ack,
  output logic [DW-1:0] o_dma_rdata,
  output logic          o_mem_rd,
  output logic          o_mem_wr,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  input  logic [DW-1:0] i_mem_rdata
);
  localparam int WW = $clog2(MAX_WAIT) + 1;
  localparam int BW = $clog2(BURST_MAX) + 1;
  typedef enum logic [1:0] {IDLE, WAIT, DMA} state_t;
  state_t        r_state, w_state_nxt;
  logic [WW-1:0] r_wait_cnt, w_wait_nxt;
  logic [BW-1:0] r_beat_cnt, w_beat_nxt, w_beat_inc;
  logic          r_dma_ack;
  logic [DW-1:0] r_dma_rdata;
  logic          w_cpu_acc, w_dma_own;
  assign w_cpu_acc   = i_cpu_rd | i_cpu_wr;
  assign w_dma_own   = r_state == DMA;
  assign w_beat_inc  = r_beat_cnt + BW'(1);
  assign o_cpu_rdata = i_mem_rdata;
  assign o_cpu_stall = w_dma_own & w_cpu_acc;
  assign o_dma_gnt   = w_dma_own & i_dma_req;
  assign o_dma_ack   = r_dma_ack;
  assign o_dma_rdata = r_dma_rdata;
  assign o_mem_rd    = w_dma_own ? i_dma_req & ~i_dma_we : i_cpu_rd;
  assign o_mem_wr    = w_dma_own ? i_dma_req & i_dma_we : i_cpu_wr;
  assign o_mem_addr  = w_dma_own ? i_dma_addr : i_cpu_addr;
  assign o_mem_wdata = w_dma_own ? i_dma_wdata : i_cpu_wdata;
  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    w_beat_nxt  = r_beat_cnt;
    case (r_state)
      IDLE:
        if (i_dma_req) begin
          w_state_nxt = w_cpu_acc ? WAIT : DMA;
          w_wait_nxt  = w_cpu_acc ? WW'(1) : '0;
          w_beat_nxt  = '0;
        end
      WAIT:
        if (!i_dma_req) begin
          w_state_nxt = IDLE;
          w_wait_nxt  = '0;
        end else if (!w_cpu_acc || r_wait_cnt == WW'(MAX_WAIT)) begin
          w_state_nxt = DMA;
          w_wait_nxt  = '0;
          w_beat_nxt  = '0;
        end else
          w_wait_nxt = r_wait_cnt + WW'(1);
      DMA:
        if (!i_dma_req)
          w_state_nxt = IDLE;
        else begin
          w_beat_nxt = w_beat_inc;
          // burst exhausted: a still-busy CPU gets at least one cycle before the next burst
          if (w_beat_inc == BW'(BURST_MAX)) begin
            w_state_nxt = w_cpu_acc ? WAIT : IDLE;
            w_wait_nxt  = w_cpu_acc ? WW'(1) : '0;
          end
        end
      default: w_state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_wait_cnt  <= '0;
      r_beat_cnt  <= '0;
      r_dma_ack   <= 1'b0;
      r_dma_rdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_wait_cnt  <= w_wait_nxt;
      r_beat_cnt  <= w_beat_nxt;
      r_dma_ack   <= o_dma_gnt;
      r_dma_rdata <= (o_dma_gnt & ~i_dma_we) ? i_mem_rdata : r_dma_rdata;
    end
endmodule
